// File: rtl/fp_conv_pkg.sv
// Shared definitions for the fp16 -> fp32 stream widener.
// Field widths of binary16/binary32, exponent bias delta, quiet-NaN bit position,
// the converter FSM state encoding and a clog2 helper used to size the element index.
package fp_conv_pkg;

  localparam int unsigned HALF_EXP_W = 5;
  localparam int unsigned HALF_MAN_W = 10;
  localparam int unsigned SGL_EXP_W  = 8;
  localparam int unsigned SGL_MAN_W  = 23;
  localparam int unsigned BIAS_DELTA = 112;  // 127 - 15
  localparam int unsigned QNAN_BIT   = 22;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } conv_state_e;

  // Minimum 1 so a degenerate size still yields a legal vector width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fp16_to_fp32_lane.sv
// Combinational binary16 -> binary32 converter for a single element.
// Ports:
//   half   in  16  binary16 element {s, e[4:0], m[9:0]}
//   single out 32  binary32 element {S, E[7:0], M[22:0]}
// Zero, normal, Inf and NaN (quiet bit forced, payload kept) are always handled.
// Build option FP16_DENORM_EN: when defined, subnormals are normalised exactly using a
// 10-bit leading-zero count; when undefined they flush to signed zero and no LZC exists.
module fp16_to_fp32_lane
  import fp_conv_pkg::*;
(
  input  logic [15:0] half,
  output logic [31:0] single
);

  localparam int unsigned ManPad = SGL_MAN_W - HALF_MAN_W;

  logic                  sign;
  logic [HALF_EXP_W-1:0] exp_h;
  logic [HALF_MAN_W-1:0] man_h;
  logic [SGL_EXP_W-1:0]  sgl_exp;
  logic [SGL_MAN_W-1:0]  sgl_man;

  assign sign  = half[15];
  assign exp_h = half[14:10];
  assign man_h = half[9:0];

`ifdef FP16_DENORM_EN
  logic [3:0]            lzc;
  logic                  found;
  logic [3:0]            shift;
  logic [HALF_MAN_W-1:0] man_norm;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = HALF_MAN_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (man_h[i]) found = 1'b1;
        else          lzc   = lzc + 4'd1;
      end
    end
  end

  // Shift the leading one out; it becomes the implicit bit.
  assign shift    = lzc + 4'd1;
  assign man_norm = man_h << shift;
`endif

  always_comb begin
    sgl_exp = '0;
    sgl_man = '0;
    if (exp_h == '1) begin
      sgl_exp = '1;
      if (man_h != '0) begin
        sgl_man = {man_h, {ManPad{1'b0}}} | (23'd1 << QNAN_BIT);
      end
    end else if (exp_h != '0) begin
      sgl_exp = {3'b000, exp_h} + 8'(BIAS_DELTA);
      sgl_man = {man_h, {ManPad{1'b0}}};
    end
`ifdef FP16_DENORM_EN
    else if (man_h != '0) begin
      sgl_exp = 8'(BIAS_DELTA + 1) - {4'b0000, shift};
      sgl_man = {man_norm, {ManPad{1'b0}}};
    end
`endif
  end

  assign single = {sign, sgl_exp, sgl_man};

endmodule

// File: rtl/fp16_stream_to_fp32.sv
// Converts a NODES-wide binary16 vector to binary32, LANES elements per cycle.
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   in_valid / in_ready  input handshake; input_fc captured on acceptance
//   input_fc             NODES x 16, element i at [16*i +: 16]
//   out_valid/out_ready  output handshake; output_fc stable while out_valid
//   output_fc            NODES x 32, element i at [32*i +: 32]
//   busy                 high whenever the FSM is not idle
// FSM Idle -> Conv (ceil(NODES/LANES) beats) -> Done -> Idle. output_fc updates in place
// during Conv and otherwise holds the last completed vector.
// Build option FP16_DENORM_EN selects exact subnormal normalisation in each lane.
module fp16_stream_to_fp32
  import fp_conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_1 = 16,
  parameter int unsigned DATA_WIDTH_2 = 32,
  parameter int unsigned NODES        = 400,
  parameter int unsigned LANES        = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH_1*NODES-1:0]   input_fc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH_2*NODES-1:0]   output_fc,
  output logic                            busy
);

  // Wide enough to hold idx + LANES after the last beat without wrapping.
  localparam int unsigned IdxW = clog2(NODES + LANES + 1);

  conv_state_e              state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH_1-1:0]  in_buf_q  [NODES];
  logic [DATA_WIDTH_2-1:0]  out_buf_q [NODES];
  logic [15:0]              lane_in   [LANES];
  logic [31:0]              lane_out  [LANES];
  logic                     accept;
  logic                     last_beat;

  assign accept    = (state_q == StIdle) && in_valid;
  assign last_beat = (int'(idx_q) + LANES) >= NODES;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        idx_d = idx_q + IdxW'(LANES);
        if (last_beat) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  // Lane k sees element idx+k; past the end of the vector it sees zero and is never written.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      lane_in[k] = '0;
      for (int n = 0; n < int'(NODES); n++) begin
        if (int'(idx_q) + k == n) lane_in[k] = in_buf_q[n][15:0];
      end
    end
  end

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    fp16_to_fp32_lane u_lane (
      .half   (lane_in[k]),
      .single (lane_out[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Input buffer is pure datapath; it is only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int n = 0; n < int'(NODES); n++) begin
        in_buf_q[n] <= input_fc[DATA_WIDTH_1*n +: DATA_WIDTH_1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < int'(NODES); n++) out_buf_q[n] <= '0;
    end else if (state_q == StConv) begin
      for (int k = 0; k < int'(LANES); k++) begin
        for (int n = 0; n < int'(NODES); n++) begin
          if (int'(idx_q) + k == n) out_buf_q[n] <= DATA_WIDTH_2'(lane_out[k]);
        end
      end
    end
  end

  for (genvar n = 0; n < int'(NODES); n++) begin : g_out
    assign output_fc[DATA_WIDTH_2*n +: DATA_WIDTH_2] = out_buf_q[n];
  end

endmodule
